// File: rtl/wave_gen_pkg.sv
// Shared types and default widths for the multi-mode waveform generator.
package wave_gen_pkg;

  localparam int unsigned WAVE_WIDTH_DEF   = 16;
  localparam int unsigned WAVE_PRESC_W_DEF = 16;

  typedef enum logic [1:0] {
    MODE_SAW  = 2'd0,
    MODE_RAMP = 2'd1,
    MODE_TRI  = 2'd2,
    MODE_SQR  = 2'd3
  } wave_mode_t;

  // UP covers every non-triangle mode and the rising half of the triangle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } wave_state_t;

endpackage

// File: rtl/wave_prescaler.sv
// Step-rate divider: pulses step once every prescaler+1 clocks while not cleared.
module wave_prescaler
  import wave_gen_pkg::*;
#(
  parameter int unsigned PRESC_W = WAVE_PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [PRESC_W-1:0] prescaler,
  output logic               step
);

  logic [PRESC_W-1:0] cnt;

  // prescaler is live, so a lowered value lets cnt free-wrap until it matches
  assign step = (cnt == prescaler);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/wave_gen.sv
// Multi-mode waveform generator (saw, ramp-down, triangle, square) with period strobe.
// Optional macro WAVE_GEN_DUTY_EN enables a programmable square duty threshold.
module wave_gen
  import wave_gen_pkg::*;
#(
  parameter int unsigned WIDTH   = WAVE_WIDTH_DEF,
  parameter int unsigned PRESC_W = WAVE_PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   amplitude,
  input  logic [PRESC_W-1:0] prescaler,
  input  logic [WIDTH-1:0]   duty,
  output logic [WIDTH-1:0]   data,
  output logic               wrap
);

  wave_state_t      state, state_n;
  logic [WIDTH-1:0] ph, ph_n;
  wave_mode_t       mode_s, mode_n;
  logic [WIDTH-1:0] amp_s, amp_n;
  logic [WIDTH-1:0] data_n;
  logic             wrap_n;
  logic             reload;
  logic             step;
  logic             clr;
  logic [WIDTH-1:0] ph_inc;
  logic [WIDTH:0]   amp_p1;
  logic [WIDTH:0]   thr;

`ifdef WAVE_GEN_DUTY_EN
  logic [WIDTH-1:0] duty_s, duty_n;
`else
  logic             unused_duty;
  assign unused_duty = ^duty;
`endif

  assign clr    = (state == ST_IDLE) || !ena;
  assign ph_inc = ph + WIDTH'(1);

  wave_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .prescaler (prescaler),
    .step      (step)
  );

  // Phase FSM, shadow reload at period boundaries and next output sample
  always_comb begin
    state_n = state;
    ph_n    = ph;
    mode_n  = mode_s;
    amp_n   = amp_s;
    data_n  = '0;
    wrap_n  = 1'b0;
    reload  = 1'b0;
    amp_p1  = '0;
    thr     = '0;
`ifdef WAVE_GEN_DUTY_EN
    duty_n  = duty_s;
`endif

    if (!ena) begin
      state_n = ST_IDLE;
      ph_n    = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_UP;
          ph_n    = '0;
          reload  = 1'b1;
        end
        ST_UP: begin
          if (step) begin
            if (ph == amp_s) begin
              ph_n   = '0;
              reload = 1'b1;
            end else begin
              ph_n = ph_inc;
              if (mode_s == MODE_TRI && ph_inc == amp_s) begin
                state_n = ST_DOWN;
              end
            end
          end
        end
        ST_DOWN: begin
          if (step) begin
            if (ph == WIDTH'(1)) begin
              ph_n    = '0;
              state_n = ST_UP;
              reload  = 1'b1;
            end else begin
              ph_n = ph - WIDTH'(1);
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
          ph_n    = '0;
        end
      endcase
    end

    if (reload) begin
      mode_n = wave_mode_t'(mode);
      amp_n  = amplitude;
      wrap_n = 1'b1;
`ifdef WAVE_GEN_DUTY_EN
      duty_n = duty;
`endif
    end

    // Square threshold held at WIDTH+1 bits so an all-ones amplitude cannot overflow
    amp_p1 = {1'b0, amp_n} + (WIDTH+1)'(1);
`ifdef WAVE_GEN_DUTY_EN
    thr = ({1'b0, duty_n} < amp_p1) ? {1'b0, duty_n} : amp_p1;
`else
    thr = amp_p1 >> 1;
`endif

    if (ena) begin
      case (mode_n)
        MODE_SAW:  data_n = ph_n;
        MODE_RAMP: data_n = amp_n - ph_n;
        MODE_TRI:  data_n = ph_n;
        MODE_SQR:  data_n = ({1'b0, ph_n} < thr) ? amp_n : '0;
        default:   data_n = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      ph     <= '0;
      mode_s <= MODE_SAW;
      amp_s  <= '0;
      data   <= '0;
      wrap   <= 1'b0;
`ifdef WAVE_GEN_DUTY_EN
      duty_s <= '0;
`endif
    end else begin
      state  <= state_n;
      ph     <= ph_n;
      mode_s <= mode_n;
      amp_s  <= amp_n;
      data   <= data_n;
      wrap   <= wrap_n;
`ifdef WAVE_GEN_DUTY_EN
      duty_s <= duty_n;
`endif
    end
  end

endmodule

// File: tb/tb_wave_gen.sv
// Self-checking bench for wave_gen: vector table, corner sequences, random run vs reference model.
module tb_wave_gen;

  localparam int unsigned W  = 16;
  localparam int unsigned PW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic [1:0]    mode;
  logic [W-1:0]  amplitude;
  logic [PW-1:0] prescaler;
  logic [W-1:0]  duty;
  logic [W-1:0]  data;
  logic          wrap;

  int checks = 0;
  int errors = 0;

  wave_gen #(.WIDTH(W), .PRESC_W(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .mode      (mode),
    .amplitude (amplitude),
    .prescaler (prescaler),
    .duty      (duty),
    .data      (data),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         ena;
    logic [1:0]   mode;
    logic [W-1:0] amp;
    logic [PW-1:0] presc;
    logic [W-1:0] duty;
    logic [W-1:0] ed;
    logic         ew;
  } vec_t;

  vec_t tbl[$];

  // Reference model: position k within the period, counted in steps
  bit      m_run;
  longint  m_c, m_k, m_A, m_duty;
  int      m_mode;
  longint  m_data;
  bit      m_wrap;

  function automatic longint m_period();
    if (m_mode == 2) return (m_A == 0) ? 1 : 2 * m_A;
    return m_A + 1;
  endfunction

  function automatic longint m_value();
    longint t;
    case (m_mode)
      0: return m_k;
      1: return m_A - m_k;
      2: return (m_k <= m_A) ? m_k : 2 * m_A - m_k;
      default: begin
`ifdef WAVE_GEN_DUTY_EN
        t = (m_duty < m_A + 1) ? m_duty : m_A + 1;
`else
        t = (m_A + 1) / 2;
`endif
        return (m_k < t) ? m_A : 0;
      end
    endcase
  endfunction

  task automatic m_latch();
    m_mode = int'(mode);
    m_A    = longint'(amplitude);
    m_duty = longint'(duty);
  endtask

  task automatic model_step();
    if (rst || !ena) begin
      m_run = 0; m_data = 0; m_wrap = 0;
    end else if (!m_run) begin
      m_run = 1; m_c = 0; m_k = 0;
      m_latch();
      m_wrap = 1;
      m_data = m_value();
    end else begin
      m_wrap = 0;
      if (m_c == longint'(prescaler)) begin
        m_c = 0;
        m_k = m_k + 1;
        if (m_k >= m_period()) begin
          m_k = 0;
          m_latch();
          m_wrap = 1;
        end
      end else begin
        m_c = (m_c + 1) % 65536;
      end
      m_data = m_value();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", nm, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] md,
                       input logic [W-1:0] a, input logic [PW-1:0] p, input logic [W-1:0] d);
    rst = r; ena = e; mode = md; amplitude = a; prescaler = p; duty = d;
  endtask

  task automatic add(input logic r, input logic e, input logic [1:0] md, input logic [W-1:0] a,
                     input logic [PW-1:0] p, input logic [W-1:0] d,
                     input logic [W-1:0] ed, input logic ew);
    vec_t v;
    v.rst = r; v.ena = e; v.mode = md; v.amp = a; v.presc = p; v.duty = d; v.ed = ed; v.ew = ew;
    tbl.push_back(v);
  endtask

  localparam int SAW_D [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
  localparam int RMP_D [5] = '{3, 2, 1, 0, 3};
`ifdef WAVE_GEN_DUTY_EN
  localparam int SQR_D [8] = '{7, 7, 0, 0, 0, 0, 0, 0};
`else
  localparam int SQR_D [8] = '{7, 7, 7, 7, 0, 0, 0, 0};
`endif
  localparam int TRI_D [14] = '{0, 0, 1, 1, 2, 2, 3, 3, 2, 2, 1, 1, 0, 0};
  localparam int SW_D  [6]  = '{3, 2, 1, 0, 0, 1};
  localparam int RS_D  [16] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 0, 0, 0, 0, 1};

  initial begin
    drive(1'b1, 1'b0, 2'd0, 16'd0, 16'd0, 16'd0);
    m_run = 0; m_c = 0; m_k = 0; m_A = 0; m_duty = 0; m_mode = 0; m_data = 0; m_wrap = 0;

    // Vector table: reset overriding ena, saw, idle, ramp-down, idle, square
    add(1, 1, 2'd0, 16'd3, 16'd0, 16'd2, 16'd0, 1'b0);
    for (int i = 0; i < 9; i++) add(0, 1, 2'd0, 16'd3, 16'd0, 16'd2, 16'(SAW_D[i]), 1'(i % 4 == 0));
    add(0, 0, 2'd1, 16'd3, 16'd0, 16'd2, 16'd0, 1'b0);
    for (int i = 0; i < 5; i++) add(0, 1, 2'd1, 16'd3, 16'd0, 16'd2, 16'(RMP_D[i]), 1'(i % 4 == 0));
    add(0, 0, 2'd3, 16'd7, 16'd0, 16'd2, 16'd0, 1'b0);
    for (int i = 0; i < 8; i++) add(0, 1, 2'd3, 16'd7, 16'd0, 16'd2, 16'(SQR_D[i]), 1'(i == 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].ena, tbl[i].mode, tbl[i].amp, tbl[i].presc, tbl[i].duty);
      tick();
      chk($sformatf("vec%0d data", i), 32'(data), 32'(tbl[i].ed));
      chk($sformatf("vec%0d wrap", i), 32'(wrap), 32'(tbl[i].ew));
    end

    // Triangle A=3 P=1: two clocks per step, 12-clock period
    drive(0, 0, 2'd2, 16'd3, 16'd1, 16'd0); tick();
    chk("tri idle", 32'(data), 32'd0);
    drive(0, 1, 2'd2, 16'd3, 16'd1, 16'd0);
    for (int i = 0; i < 14; i++) begin
      tick();
      chk($sformatf("tri%0d data", i), 32'(data), 32'(TRI_D[i]));
      chk($sformatf("tri%0d wrap", i), 32'(wrap), 32'(i % 12 == 0));
    end

    // Mode change mid-period only takes effect at the next wrap
    drive(0, 0, 2'd1, 16'd3, 16'd0, 16'd0); tick();
    drive(0, 1, 2'd1, 16'd3, 16'd0, 16'd0);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) mode = 2'd0;
      tick();
      chk($sformatf("msw%0d data", i), 32'(data), 32'(SW_D[i]));
      chk($sformatf("msw%0d wrap", i), 32'(wrap), 32'(i == 0 || i == 4));
    end

    // Reset mid-step, then restart with ena still high
    drive(0, 0, 2'd0, 16'd5, 16'd2, 16'd0); tick();
    drive(0, 1, 2'd0, 16'd5, 16'd2, 16'd0);
    for (int i = 0; i < 16; i++) begin
      rst = (i == 11);
      tick();
      chk($sformatf("rst%0d data", i), 32'(data), 32'(RS_D[i]));
      chk($sformatf("rst%0d wrap", i), 32'(wrap), 32'(i == 0 || i == 12));
    end

    // ena drop at data=2
    drive(0, 0, 2'd0, 16'd5, 16'd0, 16'd0); tick();
    drive(0, 1, 2'd0, 16'd5, 16'd0, 16'd0);
    tick(); tick(); tick();
    chk("ena data2", 32'(data), 32'd2);
    ena = 0; tick();
    chk("ena drop data", 32'(data), 32'd0);
    chk("ena drop wrap", 32'(wrap), 32'd0);

    // A=0 triangle, P=2: data stuck at 0, wrap every 3 clocks
    drive(0, 1, 2'd2, 16'd0, 16'd2, 16'd0);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("a0_%0d data", i), 32'(data), 32'd0);
      chk($sformatf("a0_%0d wrap", i), 32'(wrap), 32'(i % 3 == 0));
    end

    // All-ones amplitude square: threshold must not overflow
    drive(0, 0, 2'd3, 16'hFFFF, 16'd0, 16'hFFFF); tick();
    ena = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("sqmax%0d data", i), 32'(data), 32'hFFFF);
    end

    // Random run against the reference model
    drive(1, 0, 2'd0, 16'd0, 16'd0, 16'd0); tick();
    rst = 0;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (ena) begin
        if ($urandom_range(0, 149) == 0) ena = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        ena = 1;
        prescaler = 16'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 19) == 0) begin
        mode      = 2'($urandom_range(0, 3));
        amplitude = 16'($urandom_range(0, 12));
        duty      = 16'($urandom_range(0, 14));
      end
      tick();
      chk($sformatf("rnd%0d data", i), 32'(data), 32'(m_data));
      chk($sformatf("rnd%0d wrap", i), 32'(wrap), 32'(m_wrap));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
